// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Each channel produces a square wave (toggle) or a one-cycle strobe (pulse) every div clocks.
`timescale 1ns/1ps
module prog_clock_divider #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 250000,
  parameter bit          DEFAULT_MODE = 1'b0,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_div,
  input  logic                wr_mode,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] indicator
);

  logic [WIDTH-1:0] div_q [CHANNELS];
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic             mode_q [CHANNELS];
  logic             wr_ok;

  // Indices beyond the last channel are dropped rather than aliased.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(CHANNELS));

  function automatic logic is_event(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] div);
    return cnt == (div - WIDTH'(1));
  endfunction

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]  <= WIDTH'(DEFAULT_DIV);
        mode_q[i] <= DEFAULT_MODE;
        cnt_q[i]  <= '0;
      end
      clk_out   <= '0;
      indicator <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ok && (wr_ch == CH_W'(i))) begin
          div_q[i]   <= wr_div;
          mode_q[i]  <= wr_mode;
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
        end else if (sync || !en[i] || (div_q[i] == '0)) begin
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
        end else if (is_event(cnt_q[i], div_q[i])) begin
          cnt_q[i]     <= '0;
          indicator[i] <= ~indicator[i];
          clk_out[i]   <= mode_q[i] ? 1'b1 : ~clk_out[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + WIDTH'(1);
          if (mode_q[i])
            clk_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: 3 channels, 8-bit divider, reset divide of 3 in toggle mode.
`timescale 1ns/1ps
module tb_prog_clock_divider;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       sync;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_div;
  logic       wr_mode;
  logic [2:0] clk_out;
  logic [2:0] indicator;

  prog_clock_divider #(
    .CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3), .DEFAULT_MODE(1'b0)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
    .clk_out(clk_out), .indicator(indicator)
  );

  always #5 clk_in = ~clk_in;

  int edge_n = 0;
  always @(posedge clk_in) edge_n <= edge_n + 1;

  typedef struct {
    int         cyc;
    logic [2:0] ck;
    logic [2:0] ind;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic push(input int c, input logic [2:0] ck, input logic [2:0] id, input string nm);
    sb.push_back('{c, ck, id, nm});
  endtask

  // Monitor: outputs are compared mid-cycle against any expectation due at this edge.
  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      cur = sb.pop_front();
      n_vec++;
      if (cur.cyc < edge_n) begin
        n_fail++;
        $display("FAIL %s: edge %0d passed unchecked (now %0d)", cur.nm, cur.cyc, edge_n);
      end else if (clk_out !== cur.ck || indicator !== cur.ind) begin
        n_fail++;
        $display("FAIL %s @edge %0d: clk_out=%b indicator=%b, expected clk_out=%b indicator=%b",
                 cur.nm, edge_n, clk_out, indicator, cur.ck, cur.ind);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic set_wr(input logic [1:0] ch, input logic [7:0] d, input logic m);
    wr_en = 1'b1; wr_ch = ch; wr_div = d; wr_mode = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations outstanding", sb.size());
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 3'b111; sync = 1'b0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_div = 8'd0; wr_mode = 1'b0;

    // Reset defaults: D=3 toggle, released after edge 2 -> events at 5, 8, 11
    push(2,  3'b000, 3'b000, "reset_state");
    push(4,  3'b000, 3'b000, "default_pre_event");
    push(5,  3'b111, 3'b111, "default_rise");
    push(7,  3'b111, 3'b111, "default_hold_high");
    push(8,  3'b000, 3'b000, "default_fall");
    push(11, 3'b111, 3'b111, "default_rise2");
    wait_to(2);
    rst = 1'b0;

    // ch1 <- D=4 pulse at edge 12; ch0/ch2 keep their events at 14, 17, 20, 23
    push(12, 3'b101, 3'b111, "wr_ch1_restart");
    push(15, 3'b000, 3'b010, "ch1_counting");
    push(16, 3'b010, 3'b000, "ch1_pulse1");
    push(17, 3'b101, 3'b101, "ch1_pulse1_end");
    push(20, 3'b010, 3'b010, "ch1_pulse2");
    push(21, 3'b000, 3'b010, "ch1_pulse2_end");
    push(24, 3'b111, 3'b101, "ch1_pulse3");
    wait_to(11);
    set_wr(2'd1, 8'd4, 1'b1);
    tick();
    wr_en = 1'b0;

    // ch1 D=1 pulse (edge 25), ch2 D=1 toggle (26), ch0 D=0 (27)
    push(25, 3'b101, 3'b101, "wr_ch1_d1");
    push(26, 3'b010, 3'b110, "wr_ch2_d1");
    push(27, 3'b110, 3'b000, "wr_ch0_d0");
    push(28, 3'b010, 3'b110, "d1_even");
    push(29, 3'b110, 3'b000, "d1_odd");
    push(34, 3'b010, 3'b110, "d1_even_later_d0_frozen");
    wait_to(24);
    set_wr(2'd1, 8'd1, 1'b1);
    tick();
    set_wr(2'd2, 8'd1, 1'b0);
    tick();
    set_wr(2'd0, 8'd0, 1'b0);
    tick();
    wr_en = 1'b0;

    // ch0 D=5, ch2 D=7, sync at edge 38 -> events at 43 and 45
    push(38, 3'b000, 3'b000, "sync_clears");
    push(42, 3'b010, 3'b000, "post_sync_wait");
    push(43, 3'b011, 3'b011, "sync_plus5_ch0");
    push(44, 3'b011, 3'b001, "sync_plus6");
    push(45, 3'b111, 3'b111, "sync_plus7_ch2");
    wait_to(34);
    set_wr(2'd0, 8'd5, 1'b0);
    tick();
    set_wr(2'd2, 8'd7, 1'b0);
    tick();
    wr_en = 1'b0;
    wait_to(37);
    sync = 1'b1;
    tick();
    sync = 1'b0;

    // write ch0 D=2 together with sync at 46, then an out-of-range write at 47
    push(46, 3'b000, 3'b111, "wr_and_sync");
    push(47, 3'b010, 3'b101, "bad_ch_ignored");
    push(48, 3'b011, 3'b110, "ch0_d2_event1");
    push(50, 3'b010, 3'b111, "ch0_d2_event2");
    push(53, 3'b111, 3'b000, "ch2_d7_event");
    wait_to(45);
    set_wr(2'd0, 8'd2, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    set_wr(2'd3, 8'd9, 1'b1);
    tick();
    wr_en = 1'b0;

    // disable ch0 for edge 54, re-enable afterwards -> event at 56
    push(54, 3'b110, 3'b010, "ch0_disabled");
    push(56, 3'b111, 3'b011, "ch0_reenabled_event");
    wait_to(53);
    en = 3'b110;
    tick();
    en = 3'b111;

    // async reset mid-period after edge 57, released after edge 59 -> events at 62, 65
    wait_to(57);
    #2;
    rst = 1'b1;
    en  = 3'b000;
    push(57, 3'b000, 3'b000, "async_reset_immediate");
    push(59, 3'b000, 3'b000, "reset_held");
    push(61, 3'b000, 3'b000, "post_reset_counting");
    push(62, 3'b111, 3'b111, "post_reset_event1");
    push(65, 3'b000, 3'b000, "post_reset_event2");
    wait_to(59);
    rst = 1'b0;
    en  = 3'b111;

    wait_to(65);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
